// File: rtl/mem_prio_readout.sv
// Memory readout controller for the 12-input memory-data mux.
// At each BX boundary it latches per-memory entry counts, then reads every non-empty
// memory back-to-back, lowest index first. The select code and BX go through a
// MEM_LAT-deep delay line so they arrive at the mux together with the read data.
module mem_prio_readout #(
    parameter int unsigned NMEM    = 12,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_bx,
    input  logic [2:0]                   BX,
    input  logic [NMEM*(ADDR_W+1)-1:0]   nent,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_add,
    output logic [3:0]                   rd_sel,
    output logic [3:0]                   mux_sel,
    output logic [2:0]                   mux_bx,
    output logic                         done,
    output logic                         truncated
);

    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned IDX_W = $clog2(NMEM);
    localparam logic [CW-1:0] MaxCnt = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e              state_q, state_d;
    logic [NMEM-1:0]     pend_q, pend_d, new_pend, cur_oh;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]       nent_q [NMEM];
    logic [2:0]          bx_q;
    logic                done_q, done_d;
    logic                load;
    logic [IDX_W-1:0]    cur_idx;
    logic                last;
    logic [3:0]          sel_pipe [MEM_LAT];
    logic [2:0]          bx_pipe  [MEM_LAT];

    // Fixed mux decode: memories 0..8 -> 1..9, 9..11 -> B..D (A is skipped).
    function automatic logic [3:0] sel_code(input logic [IDX_W-1:0] m);
        logic [3:0] m4;
        m4 = 4'(m);
        if (m4 <= 4'd8) begin
            return m4 + 4'd1;
        end
        return m4 + 4'd2;
    endfunction

    // Counts larger than the memory depth are clamped to the depth.
    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v);
        return (v > MaxCnt) ? MaxCnt : v;
    endfunction

    // Priority pick of the lowest pending memory and end-of-memory detect.
    always_comb begin
        cur_idx = '0;
        for (int i = NMEM - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                cur_idx = IDX_W'(i);
            end
        end
        cur_oh = NMEM'(1) << cur_idx;
        last   = ({1'b0, cnt_q} == (nent_q[cur_idx] - CW'(1)));
        for (int i = 0; i < NMEM; i++) begin
            new_pend[i] = |nent[i*CW +: CW];
        end
    end

    // Next-state: new_bx always reloads (aborting any readout), otherwise walk the mask.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        if (new_bx) begin
            load    = 1'b1;
            pend_d  = new_pend;
            cnt_d   = '0;
            state_d = (|new_pend) ? StRead : StIdle;
            done_d  = ~|new_pend;
        end else if (state_q == StRead) begin
            if (last) begin
                pend_d = pend_q & ~cur_oh;
                cnt_d  = '0;
                if (~|(pend_q & ~cur_oh)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    // Read-side outputs; a read coinciding with new_bx or reset is dropped.
    always_comb begin
        rd_en     = (state_q == StRead) && !new_bx && !reset;
        rd_sel    = rd_en ? sel_code(cur_idx) : 4'h0;
        rd_add    = rd_en ? cnt_q : '0;
        truncated = (state_q == StRead) && new_bx && !reset;
        done      = done_q;
        mux_sel   = sel_pipe[MEM_LAT-1];
        mux_bx    = bx_pipe[MEM_LAT-1];
    end

    // Control state, latched counts and BX.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pend_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            bx_q    <= '0;
            for (int i = 0; i < NMEM; i++) begin
                nent_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (load) begin
                bx_q <= BX;
                for (int i = 0; i < NMEM; i++) begin
                    nent_q[i] <= clamp(nent[i*CW +: CW]);
                end
            end
        end
    end

    // Delay line aligning select code and BX with memory read data; shifts every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                sel_pipe[i] <= '0;
                bx_pipe[i]  <= '0;
            end
        end else begin
            sel_pipe[0] <= rd_sel;
            bx_pipe[0]  <= bx_q;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                sel_pipe[i] <= sel_pipe[i-1];
                bx_pipe[i]  <= bx_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_prio_readout.sv
// Directed bench for mem_prio_readout with MEM_LAT=1. Inputs change on the falling
// edge; outputs are checked 1 time unit later, well before the next rising edge.
module tb_mem_prio_readout;

    localparam int unsigned NMEM   = 12;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CW     = ADDR_W + 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   new_bx;
    logic [2:0]             BX;
    logic [NMEM*CW-1:0]     nent;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_add;
    logic [3:0]             rd_sel;
    logic [3:0]             mux_sel;
    logic [2:0]             mux_bx;
    logic                   done;
    logic                   truncated;

    int n_checks = 0;
    int n_pass   = 0;

    mem_prio_readout #(
        .NMEM    (NMEM),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .new_bx    (new_bx),
        .BX        (BX),
        .nent      (nent),
        .rd_en     (rd_en),
        .rd_add    (rd_add),
        .rd_sel    (rd_sel),
        .mux_sel   (mux_sel),
        .mux_bx    (mux_bx),
        .done      (done),
        .truncated (truncated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_n(input int idx, input logic [CW-1:0] v);
        nent[idx*CW +: CW] = v;
    endtask

    task automatic chk_rd(input string tag, input logic en, input logic [3:0] sel,
                          input logic [ADDR_W-1:0] add);
        chk({tag, "_rd"}, {rd_en, rd_sel, rd_add}, {en, sel, add});
    endtask

    task automatic chk_mux(input string tag, input logic [3:0] sel, input logic [2:0] bx);
        chk({tag, "_mux"}, {mux_sel, mux_bx}, {sel, bx});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_all0"}, {rd_en, rd_add, rd_sel, mux_sel, mux_bx, done, truncated}, '0);
    endtask

    // Issue one new_bx pulse with the given BX; nent must already be set.
    task automatic pulse_bx(input logic [2:0] bx);
        new_bx = 1'b1;
        BX     = bx;
    endtask

    initial begin
        int reads;
        int last_add;
        int budget;

        reset  = 1'b1;
        new_bx = 1'b0;
        BX     = '0;
        nent   = '0;

        // Reset held for three cycles, then released.
        repeat (3) cyc();
        settle();
        chk_zero("in_reset");
        reset = 1'b0;
        cyc(); settle();
        chk_zero("post_reset0");
        cyc(); settle();
        chk_zero("post_reset1");

        // BX=3, nent0=2, nent4=1: reads (1,0),(1,1),(5,0).
        cyc();
        nent = '0; set_n(0, 7'd2); set_n(4, 7'd1);
        pulse_bx(3'd3);
        settle();
        chk("t2_c0_rden", {31'b0, rd_en}, 32'd0);
        cyc(); new_bx = 1'b0; settle();
        chk_rd("t2_c1", 1'b1, 4'h1, 6'd0);
        chk_mux("t2_c1", 4'h0, 3'd0);
        cyc(); settle();
        chk_rd("t2_c2", 1'b1, 4'h1, 6'd1);
        chk_mux("t2_c2", 4'h1, 3'd3);
        cyc(); settle();
        chk_rd("t2_c3", 1'b1, 4'h5, 6'd0);
        chk_mux("t2_c3", 4'h1, 3'd3);
        chk("t2_c3_done", {31'b0, done}, 32'd0);
        cyc(); settle();
        chk_rd("t2_c4", 1'b0, 4'h0, 6'd0);
        chk_mux("t2_c4", 4'h5, 3'd3);
        chk("t2_c4_done", {31'b0, done}, 32'd1);
        cyc(); settle();
        chk("t2_c5_done", {31'b0, done}, 32'd0);
        chk_mux("t2_c5", 4'h0, 3'd3);

        // nent9=1, nent11=2: codes B, D, D.
        cyc();
        nent = '0; set_n(9, 7'd1); set_n(11, 7'd2);
        pulse_bx(3'd5);
        cyc(); new_bx = 1'b0; settle();
        chk_rd("t3_c1", 1'b1, 4'hB, 6'd0);
        cyc(); settle();
        chk_rd("t3_c2", 1'b1, 4'hD, 6'd0);
        chk_mux("t3_c2", 4'hB, 3'd5);
        cyc(); settle();
        chk_rd("t3_c3", 1'b1, 4'hD, 6'd1);
        cyc(); settle();
        chk_rd("t3_c4", 1'b0, 4'h0, 6'd0);
        chk("t3_c4_done", {31'b0, done}, 32'd1);
        chk_mux("t3_c4", 4'hD, 3'd5);

        // All counts zero: no reads, one done pulse.
        cyc();
        nent = '0;
        pulse_bx(3'd1);
        cyc(); new_bx = 1'b0; settle();
        chk_rd("t4_c1", 1'b0, 4'h0, 6'd0);
        chk("t4_c1_done", {31'b0, done}, 32'd1);
        chk("t4_c1_msel", {28'b0, mux_sel}, 32'd0);
        cyc(); settle();
        chk("t4_c2_done", {31'b0, done}, 32'd0);
        chk_rd("t4_c2", 1'b0, 4'h0, 6'd0);
        chk("t4_c2_msel", {28'b0, mux_sel}, 32'd0);

        // nent0=40 at BX=3, interrupted 10 cycles later by BX=4, nent2=1.
        cyc();
        nent = '0; set_n(0, 7'd40);
        pulse_bx(3'd3);
        cyc(); new_bx = 1'b0;
        repeat (8) cyc();
        settle();
        chk_rd("t5_c9", 1'b1, 4'h1, 6'd8);
        cyc();
        nent = '0; set_n(2, 7'd1);
        pulse_bx(3'd4);
        settle();
        chk("t5_c10_trunc", {31'b0, truncated}, 32'd1);
        chk("t5_c10_rden", {31'b0, rd_en}, 32'd0);
        chk_mux("t5_c10", 4'h1, 3'd3);
        cyc(); new_bx = 1'b0; settle();
        chk("t5_c11_trunc", {31'b0, truncated}, 32'd0);
        chk_rd("t5_c11", 1'b1, 4'h3, 6'd0);
        chk_mux("t5_c11", 4'h0, 3'd3);
        cyc(); settle();
        chk_mux("t5_c12", 4'h3, 3'd4);
        chk("t5_c12_done", {31'b0, done}, 32'd1);
        chk_rd("t5_c12", 1'b0, 4'h0, 6'd0);

        // Count above depth clamps: nent0=100 gives 64 reads ending at address 63.
        cyc();
        nent = '0; set_n(0, 7'd100);
        pulse_bx(3'd2);
        cyc(); new_bx = 1'b0;
        reads    = 0;
        last_add = -1;
        budget   = 200;
        settle();
        while (!done && budget > 0) begin
            if (rd_en) begin
                reads++;
                last_add = int'(rd_add);
            end
            cyc(); settle();
            budget--;
        end
        chk("t6_done_seen", {31'b0, done}, 32'd1);
        chk("t6_reads", 32'(reads), 32'd64);
        chk("t6_last_add", 32'(last_add), 32'd63);

        // Reset together with new_bx mid-readout.
        cyc();
        nent = '0; set_n(0, 7'd40);
        pulse_bx(3'd6);
        cyc(); new_bx = 1'b0;
        repeat (3) cyc();
        settle();
        chk_rd("t7_running", 1'b1, 4'h1, 6'd3);
        cyc();
        reset = 1'b1;
        set_n(1, 7'd5);
        pulse_bx(3'd7);
        cyc(); reset = 1'b0; new_bx = 1'b0; settle();
        chk_zero("t7_after_rst0");
        cyc(); settle();
        chk_zero("t7_after_rst1");
        cyc(); settle();
        chk_zero("t7_after_rst2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_prio_readout.md
Name: mem_prio_readout

Overview:
- Upstream control stage for the 12-input memory-data mux.
- At each BX boundary it latches per-memory entry counts and builds a pending mask. It then reads every non-empty memory out back-to-back, lowest index first, generating read address and read enable.
- It drives the mux select code and BX, delayed to line up with memory read data.

Parameters:
- NMEM, 12, number of source memories (select code table below is fixed for 12).
- ADDR_W, 6, memory read-address width; entry counts are ADDR_W+1 bits wide.
- MEM_LAT, 1, memory read latency in clk cycles (address to data); range 1..3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- new_bx  in  1  one-cycle pulse marking a BX boundary.
- BX  in  3  BX number of the event whose memories are to be read, sampled on new_bx.
- nent  in  NMEM*(ADDR_W+1)  packed entry counts; memory i occupies bits [i*(ADDR_W+1) +: ADDR_W+1]; sampled on new_bx.
- rd_en  out  1  read strobe to the memories.
- rd_add  out  ADDR_W  read address.
- rd_sel  out  4  select code of the memory being read this cycle; 0 when idle.
- mux_sel  out  4  rd_sel delayed MEM_LAT cycles; feeds the mux sel input.
- mux_bx  out  3  latched BX delayed MEM_LAT cycles; feeds the mux BX input.
- done  out  1  one-cycle pulse after the last read of a BX.
- truncated  out  1  one-cycle pulse when new_bx aborts an unfinished readout.

Behaviour:
- Select code table, fixed to match the mux decode:
  - memory 0..8 -> 4'h1..4'h9;
  - memory 9 -> 4'hB, memory 10 -> 4'hC, memory 11 -> 4'hD;
  - 4'h0 = no data. Codes 4'hA, 4'hE and 4'hF are never emitted.
- Reset:
  - state IDLE, pending mask 0, read counter 0;
  - rd_en, rd_add, rd_sel, mux_sel, mux_bx, done and truncated all 0;
  - delay pipeline cleared to 0.
  - Reset has priority over new_bx in the same cycle.
- State IDLE:
  - Outputs idle (rd_en=0, rd_sel=0).
  - On new_bx:
    - latch BX into bx_rd and latch nent;
    - pending[i] = (nent_i != 0);
    - go to READ if pending != 0.
  - If pending == 0, stay in IDLE, emit done the following cycle, and emit no reads.
- State READ, one read per cycle with no bubbles:
  - Current memory m = lowest set bit of pending.
  - rd_en=1, rd_sel=code(m), rd_add=counter.
  - If counter == nent_m-1: clear pending[m] and reset counter to 0. The next cycle starts the next pending memory immediately.
  - Otherwise increment counter.
  - When the last pending bit clears, go to IDLE and pulse done in the cycle after the final read.
- First read occurs in the cycle after new_bx.
- Total reads per BX = sum of nent_i.
- Counts above 2^ADDR_W are clamped to 2^ADDR_W.
- new_bx while in READ:
  - Current read is dropped, truncated=1 for that cycle, no done pulse.
  - New counts and BX are latched and readout restarts from the lowest pending memory in the next cycle.
- Delay line:
  - mux_sel and mux_bx are rd_sel and bx_rd registered through exactly MEM_LAT stages.
  - The mux adds one further register, so stream word n appears MEM_LAT+1 cycles after read n.
  - mux_sel=0 whenever the corresponding rd_en was 0.
  - The delay line keeps shifting across a BX boundary, so in-flight words keep their own BX.

Test Plan:
- reset held 3 cycles, then released -> all outputs 0, no rd_en until first new_bx.
- new_bx with BX=3, nent_0=2, nent_4=1, others 0 -> reads (1,0),(1,1),(5,0) in consecutive cycles starting one cycle after new_bx; done one cycle after the last read; mux_sel shows 1,1,5 MEM_LAT cycles later with mux_bx=3.
- nent_9=1, nent_11=2, all others 0 -> rd_sel sequence B,D,D (never A); rd_add 0,0,1.
- all nent=0 on new_bx -> no rd_en; done pulses once; mux_sel stays 0.
- nent_0=40; second new_bx 10 cycles later with BX=4, nent_2=1 -> truncated pulses; next read is (3,0) with bx_rd=4; reads already issued emerge on mux_sel/mux_bx with BX 3.
- reset asserted mid-READ together with new_bx -> next cycle all outputs 0, state IDLE, pending mask 0.
